// File: rtl/axis_sum_seg7_multi_if.sv
// Stream bus for the frame-sum display: beats in, 7-segment words out.
interface axis_sum_seg7_multi_if #(
    parameter int W = 16,
    parameter int D = 4
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [6:0]   m_data [D];
    logic         m_ovf;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_ovf
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_ovf
    );
endinterface

// File: rtl/axis_sum_seg7_multi.sv
// Frame accumulator feeding a shift-add-3 BCD engine and a
// seven-segment encoder with blanking, polarity and overflow.
module axis_sum_seg7_multi #(
    parameter int W       = 16,
    parameter int N       = 3,
    parameter int D       = 4,
    parameter bit BLANK   = 1'b1,
    parameter bit ACT_LOW = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    axis_sum_seg7_multi_if.slave bus
);
    localparam int SW  = (N > 1) ? W + $clog2(N) : W + 1;
    localparam int NB  = (SW * 30103) / 100000 + 1;
    localparam int ND  = (NB > D) ? NB : D;
    localparam int CW  = $clog2(N) + 1;
    localparam int BW  = $clog2(SW + 1);
    localparam logic [6:0] OFF  = ACT_LOW ? 7'h7f : 7'h00;
    localparam logic [6:0] DASH = 7'b1000000;

    typedef enum logic [1:0] {ACC, CONV, ENC, OUT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bit_q;
    logic [4*ND-1:0] bcd;
    logic [6:0]      seg_q [D];
    logic [6:0]      enc   [D];
    logic [6:0]      pat;
    logic            ovf, ovf_q, lead;
    logic            rdy, vld, hs;

    function automatic logic [4*ND-1:0] dd_adj(input logic [4*ND-1:0] b);
        for (int i = 0; i < ND; i++)
            if (b[4*i+:4] >= 4'd5) b[4*i+:4] = b[4*i+:4] + 4'd3;
        return b;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign hs = bus.s_valid && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ACC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        vld     = 1'b0;
        unique case (state_q)
            ACC: begin
                rdy = !rst;
                if (bus.s_valid && (bus.s_last || cnt == CW'(N - 1)))
                    state_d = CONV;
            end
            CONV: if (bit_q == BW'(SW)) state_d = ENC;
            ENC:  state_d = OUT;
            OUT: begin
                vld = 1'b1;
                if (bus.m_ready) state_d = ACC;
            end
        endcase
    end

    // Bit counter value 0 clears the BCD register; 1..SW shift one bit each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            bit_q <= '0;
            bcd   <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < D; i++) seg_q[i] <= OFF;
        end else begin
            case (state_q)
                ACC: if (hs) begin
                    acc <= acc + SW'(bus.s_data);
                    cnt <= cnt + CW'(1);
                end
                CONV: begin
                    if (bit_q == '0) bcd <= '0;
                    else {bcd, acc} <= {dd_adj(bcd), acc} << 1;
                    bit_q <= (bit_q == BW'(SW)) ? '0 : bit_q + BW'(1);
                end
                ENC: begin
                    for (int i = 0; i < D; i++) seg_q[i] <= enc[i];
                    ovf_q <= ovf;
                end
                OUT: if (bus.m_ready) begin
                    acc <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Scan from the top digit so blanking stops at the first nonzero one.
    always_comb begin
        ovf  = 1'b0;
        lead = 1'b1;
        pat  = '0;
        for (int i = D; i < ND; i++)
            if (bcd[4*i+:4] != 4'd0) ovf = 1'b1;
        for (int i = D - 1; i >= 0; i--) begin
            if (bcd[4*i+:4] != 4'd0) lead = 1'b0;
            if (ovf)                            pat = DASH;
            else if (BLANK && lead && (i != 0)) pat = 7'b0000000;
            else                                pat = seg7(bcd[4*i+:4]);
            enc[i] = ACT_LOW ? ~pat : pat;
        end
    end

    assign bus.s_ready = rdy;
    assign bus.m_valid = vld;
    assign bus.m_ovf   = ovf_q;
    assign bus.m_data  = seg_q;
endmodule

// File: tb/tb_axis_sum_seg7_multi.sv
// Self-checking bench: three display configurations share one stimulus.
module tb_axis_sum_seg7_multi;
    localparam int W  = 16;
    localparam int N  = 3;
    localparam int D  = 4;
    localparam int SW = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_last = 1'b0;
    logic         m_ready = 1'b0;
    logic [27:0]  p0, p1, p2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_sum_seg7_multi_if #(.W(W), .D(D)) b0 ();
    axis_sum_seg7_multi_if #(.W(W), .D(D)) b1 ();
    axis_sum_seg7_multi_if #(.W(W), .D(D)) b2 ();

    assign b0.s_valid = s_valid;
    assign b0.s_data  = s_data;
    assign b0.s_last  = s_last;
    assign b0.m_ready = m_ready;
    assign b1.s_valid = s_valid;
    assign b1.s_data  = s_data;
    assign b1.s_last  = s_last;
    assign b1.m_ready = m_ready;
    assign b2.s_valid = s_valid;
    assign b2.s_data  = s_data;
    assign b2.s_last  = s_last;
    assign b2.m_ready = m_ready;

    assign p0 = {b0.m_data[3], b0.m_data[2], b0.m_data[1], b0.m_data[0]};
    assign p1 = {b1.m_data[3], b1.m_data[2], b1.m_data[1], b1.m_data[0]};
    assign p2 = {b2.m_data[3], b2.m_data[2], b2.m_data[1], b2.m_data[0]};

    axis_sum_seg7_multi #(.W(W), .N(N), .D(D))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    axis_sum_seg7_multi #(.W(W), .N(N), .D(D), .ACT_LOW(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    axis_sum_seg7_multi #(.W(W), .N(N), .D(D), .BLANK(1'b0))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        int          n;
        int          b[3];
        bit          last;
        int          hold;
        int          offer;
        logic [27:0] exp;
        bit          eovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Decimal digits of the sum, blanked above the top nonzero digit.
    function automatic logic [27:0] model(input longint sum, input bit blank,
                                          input bit al);
        logic [27:0] r;
        logic [6:0]  p;
        int          d[4];
        int          top;
        longint      v;
        r   = '0;
        top = 0;
        v   = sum;
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(v % 10);
            v    = v / 10;
            if (d[i] != 0) top = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (sum >= 10000)          p = 7'b1000000;
            else if (blank && i > top) p = 7'b0000000;
            else                       p = seg_of(d[i]);
            r[7*i+:7] = al ? ~p : p;
        end
        return r;
    endfunction

    task automatic check_out(input longint sum);
        chk("digits_blank", {36'h0, p0}, {36'h0, model(sum, 1'b1, 1'b0)});
        chk("digits_actlow", {36'h0, p1}, {36'h0, model(sum, 1'b1, 1'b1)});
        chk("digits_noblank", {36'h0, p2}, {36'h0, model(sum, 1'b0, 1'b0)});
        chk("ovf_blank", 64'(b0.m_ovf), 64'(sum >= 10000));
        chk("ovf_actlow", 64'(b1.m_ovf), 64'(sum >= 10000));
        chk("ovf_noblank", 64'(b2.m_ovf), 64'(sum >= 10000));
    endtask

    task automatic run_frame(input int n, input int b[3], input bit last,
                             input int hold, input int offer, input int idle,
                             input bit have_exp, input logic [27:0] exp,
                             input bit eovf);
        int     guard;
        int     lat;
        longint sum;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            if (idle > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(idle, 0)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = W'(b[k]);
            s_last  = last && (k == n - 1);
            guard   = 0;
            while (!b0.s_ready && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 200) begin
                chk("accept_timeout", 64'(guard), 64'(0));
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            sum += longint'(b[k]);
        end
        s_last  = 1'b0;
        s_data  = W'(99);
        chk("sready_drop", 64'(b0.s_ready), 64'(0));
        lat = 0;
        while (!b0.m_valid && lat < 100) begin
            if (lat < offer) chk("conv_no_accept", 64'(b0.s_ready), 64'(0));
            else s_valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        s_valid = 1'b0;
        chk("latency", 64'(lat), 64'(SW + 2));
        check_out(sum);
        if (have_exp) begin
            chk("table_digits", {36'h0, p0}, {36'h0, exp});
            chk("table_ovf", 64'(b0.m_ovf), 64'(eovf));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(b0.m_valid), 64'(1));
            chk("hold_data", {36'h0, p0}, {36'h0, model(sum, 1'b1, 1'b0)});
            chk("hold_sready", 64'(b0.s_ready), 64'(0));
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("valid_drop", 64'(b0.m_valid), 64'(0));
        chk("sready_back", 64'(b0.s_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tv[7];
        int   rb[3];
        int   one[3];
        int   n;
        bit   stray;
        tv[0] = '{3, '{3, 2, 1}, 1'b0, 0, 0,
                  {7'b0, 7'b0, 7'b0, 7'b1111101}, 1'b0};
        tv[1] = '{3, '{10, 7, 8}, 1'b0, 5, 0,
                  {7'b0, 7'b0, 7'b1011011, 7'b1101101}, 1'b0};
        tv[2] = '{2, '{4, 1, 0}, 1'b1, 0, 5,
                  {7'b0, 7'b0, 7'b0, 7'b1101101}, 1'b0};
        tv[3] = '{3, '{65535, 65535, 65535}, 1'b0, 1, 0,
                  {4{7'b1000000}}, 1'b1};
        tv[4] = '{3, '{0, 0, 0}, 1'b0, 0, 0,
                  {7'b0, 7'b0, 7'b0, 7'b0111111}, 1'b0};
        tv[5] = '{1, '{9999, 0, 0}, 1'b1, 0, 0,
                  {4{7'b1101111}}, 1'b0};
        tv[6] = '{3, '{9999, 0, 1}, 1'b0, 0, 0,
                  {4{7'b1000000}}, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mvalid", 64'(b0.m_valid), 64'(0));
        chk("rst_sready", 64'(b0.s_ready), 64'(0));
        chk("rst_movf", 64'(b0.m_ovf), 64'(0));
        chk("rst_data", {36'h0, p0}, 64'h0);
        chk("rst_data_actlow", {36'h0, p1}, 64'hfffffff);
        rst = 1'b0;
        #1;
        chk("rst_release_sready", 64'(b0.s_ready), 64'(1));

        for (int i = 0; i < 7; i++)
            run_frame(tv[i].n, tv[i].b, tv[i].last, tv[i].hold, tv[i].offer,
                      0, 1'b1, tv[i].exp, tv[i].eovf);

        // Reset in the middle of a conversion must abandon the frame.
        @(posedge clk); #1;
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = W'(7 + k);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_sready", 64'(b0.s_ready), 64'(0));
        chk("midrst_mvalid", 64'(b0.m_valid), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_release_sready", 64'(b0.s_ready), 64'(1));
        stray = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (b0.m_valid) stray = 1'b1;
        end
        chk("midrst_no_output", 64'(stray), 64'(0));
        one = '{1, 1, 1};
        run_frame(3, one, 1'b0, 0, 0, 0, 1'b1,
                  {7'b0, 7'b0, 7'b0, 7'b1001111}, 1'b0);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 3; k++)
                rb[k] = ($urandom_range(3, 0) == 0) ? 65535
                                                    : int'($urandom_range(65535, 0));
            n = int'($urandom_range(3, 1));
            run_frame(n, rb, (n < 3) ? 1'b1 : 1'($urandom_range(1, 0)),
                      int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                      2, 1'b0, 28'h0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_sum_seg7_multi.md
Name: axis_sum_seg7_multi

Overview:
- Parametrised successor to the AXI-stream sum-on-7-segment top.
- Accumulates a frame of up to N unsigned W-bit AXI-stream beats. A frame ends after N beats or at s_last.
- Converts the sum to BCD with a sequential shift-add-3 (double dabble) engine and drives D seven-segment digit patterns on a valid/ready master port.
- Adds over the previous generation: configurable digit count, early frame termination, leading-zero blanking, segment polarity and overflow indication.

Parameters:
- W, 16, width of s_data.
- N, 3, maximum beats per frame (N ≥ 1).
- D, 4, number of display digits (D ≥ 1).
- BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked).
- ACT_LOW, 0, 1 = invert all segment outputs.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input ready.
- s_data  in  W  unsigned input beat.
- s_last  in  1  marks the final beat of a short frame.
- m_valid  out  1  display word valid.
- m_ready  in  1  downstream ready.
- m_data  out  D x 7  unpacked array [D][7].
  - Index 0 is the least significant digit.
  - Bit 0..6 = segments a..g.
- m_ovf  out  1  sum ≥ 10^D, qualified by m_valid.

Behaviour:
- Accumulator width SW = W + clog2(N), minimum W+1. Accumulation cannot wrap.
- Reset (async assert, sync release), all registers cleared:
  - m_valid=0, s_ready=0 while rst=1, m_ovf=0.
  - m_data all segments off: 0 if ACT_LOW=0, all 1 if ACT_LOW=1.
  - Beat count = 0, FSM = ACC.
  - Reset in any state abandons the frame. No partial output is ever presented.
- ACC state:
  - s_ready=1.
  - Handshake = s_valid & s_ready: acc += s_data, count++.
  - Frame closes on the handshake where count reaches N-1 (Nth beat) or s_last=1. FSM goes to CONV and s_ready drops the next cycle.
  - s_last on beat 1 gives a single-beat frame.
  - s_valid low inserts idle cycles. Accumulator and count hold.
- CONV state:
  - s_ready=0.
  - Double dabble: one accumulator bit per cycle, MSB first, for exactly SW cycles.
  - The BCD register holds enough digits for 2^SW-1.
  - Then one cycle to encode and register m_data/m_ovf. FSM goes to OUT.
- Latency: m_valid rises exactly SW+2 rising edges after the edge that accepted the last beat.
- Encoding (g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - blank=0000000, dash=1000000
  - ACT_LOW inverts all of these.
- Blanking: with BLANK=1, any zero digit above the highest nonzero digit is blank. Sum 0 shows '0' on digit 0 only.
- Overflow: if any BCD digit at index ≥ D is nonzero, every digit shows dash and m_ovf=1. Otherwise m_ovf=0.
- OUT state:
  - s_ready=0, m_valid=1.
  - m_data and m_ovf are held stable until m_valid & m_ready.
  - On that edge: m_valid=0, acc and count cleared, FSM goes to ACC, and s_ready=1 from the next cycle.
  - m_data keeps its last value after m_valid falls. Downstream ignores it.
- No input skid buffer. s_data is never accepted outside ACC.

Test Plan:
1. W=16, N=3, D=4, BLANK=1. Beats 3,2,1, m_ready=1.
   - s_ready low 1 cycle after the 3rd beat.
   - m_valid asserts 20 edges after the 3rd beat (SW=18), for exactly 1 cycle.
   - Digit0=1111101 ('6'), digits1-3=0000000, m_ovf=0.
2. Beats 10,7,8 with m_ready held low for 5 cycles.
   - m_valid and m_data stay stable, s_ready=0 throughout.
   - Digit1='2' 1011011, digit0='5' 1101101.
   - ACC resumes the cycle after m_ready rises.
3. Beats 4 then 1 with s_last=1.
   - Frame closes after 2 beats, sum 5: digit0=1101101.
   - A 3rd beat offered during CONV is not accepted (s_ready=0).
4. Three beats of 65535, sum 196605.
   - m_ovf=1, all four digits=1000000.
   - With ACT_LOW=1, digits=0111111.
5. Assert rst for 1 cycle mid-CONV.
   - m_valid stays 0, s_ready=0 during rst, then 1.
   - Next frame 1,1,1 yields digit0='3' 1001111 with no residue from the aborted frame.
6. Beats 0,0,0.
   - BLANK=1: digit0=0111111, others blank.
   - BLANK=0: all four digits=0111111.
